tlight_lamp_guard: RTL and testbench



---
 rtl/tlight_lamp_guard.sv | 148 ++++++++++++++
 tb/tb_tlight_lamp_guard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlight_lamp_guard.sv
// Lamp safety stage: turns per-direction colour commands into registered one-hot lamp drives,
// and latches into a flashing-yellow fault mode on any unsafe command sequence.
package tlight_pkg;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } tlight_control_t;
endpackage

module tlight_lamp_guard
    import tlight_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 1,
    parameter int WATCHDOG_LIMIT    = 20
) (
    input  logic            clock,
    input  logic            reset_n,
    input  tlight_control_t ns,
    input  tlight_control_t we,
    input  logic            clear_fault,
    output logic [2:0]      ns_lamp,
    output logic [2:0]      we_lamp,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam int HW = $clog2(WATCHDOG_LIMIT + 2);
    localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX   = '1;
    localparam logic [HW-1:0] WD_LIMIT   = HW'(WATCHDOG_LIMIT);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t          state;
    tlight_control_t prev_ns;
    tlight_control_t prev_we;
    logic [HW-1:0]   hold_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink_on;

    logic            same_pair;
    logic [HW-1:0]   hold_next;
    logic [1:0]      viol_code;
    logic            clear_ok;
    logic            blink_wrap;
    logic            blink_next;

    function automatic logic [2:0] lamp_of(input tlight_control_t c);
        case (c)
            RED:     return 3'b100;
            YELLOW:  return 3'b010;
            GREEN:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input tlight_control_t c);
        return (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

    // Red and green must always be separated by a yellow phase.
    function automatic logic bad_step(input tlight_control_t p, input tlight_control_t c);
        return ((p == RED) && (c == GREEN)) || ((p == GREEN) && (c == RED));
    endfunction

    always_comb begin
        same_pair = (ns == prev_ns) && (we == prev_we);
        hold_next = HOLD_ONE;
        if (same_pair) begin
            hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_ONE;
        end
        viol_code = 2'd0;
        if ((ns != RED) && (we != RED)) begin
            viol_code = 2'd1;
        end else if (!is_legal(ns) || !is_legal(we) ||
                     bad_step(prev_ns, ns) || bad_step(prev_we, we)) begin
            viol_code = 2'd2;
        end else if (same_pair && (hold_cnt >= WD_LIMIT)) begin
            viol_code = 2'd3;
        end
        clear_ok   = clear_fault && (ns == RED) && (we == RED);
        blink_wrap = (blink_cnt == BLINK_LAST);
        blink_next = blink_on ^ blink_wrap;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            ns_lamp    <= 3'b100;
            we_lamp    <= 3'b100;
            fault      <= 1'b0;
            fault_code <= 2'd0;
            prev_ns    <= RED;
            prev_we    <= RED;
            hold_cnt   <= HOLD_ONE;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (viol_code != 2'd0) begin
                        // Offending command is swallowed: lamps go straight to flash-on.
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= viol_code;
                        ns_lamp    <= 3'b010;
                        we_lamp    <= 3'b010;
                        blink_cnt  <= '0;
                        blink_on   <= 1'b1;
                    end else begin
                        ns_lamp  <= lamp_of(ns);
                        we_lamp  <= lamp_of(we);
                        prev_ns  <= ns;
                        prev_we  <= we;
                        hold_cnt <= hold_next;
                    end
                end
                ST_FAULT: begin
                    if (clear_ok) begin
                        state      <= ST_RUN;
                        fault      <= 1'b0;
                        fault_code <= 2'd0;
                        ns_lamp    <= 3'b100;
                        we_lamp    <= 3'b100;
                        prev_ns    <= RED;
                        prev_we    <= RED;
                        hold_cnt   <= HOLD_ONE;
                        blink_cnt  <= '0;
                        blink_on   <= 1'b1;
                    end else begin
                        blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
                        blink_on  <= blink_next;
                        ns_lamp   <= blink_next ? 3'b010 : 3'b000;
                        we_lamp   <= blink_next ? 3'b010 : 3'b000;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_tlight_lamp_guard.sv
// Randomised bench for tlight_lamp_guard against a colour-level reference model,
// plus directed scenarios pinned with literal expectations.
module tb_tlight_lamp_guard;
    import tlight_pkg::*;

    localparam int HP = 1;
    localparam int WL = 20;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    tlight_control_t ns = RED;
    tlight_control_t we = RED;
    logic            clear_fault = 1'b0;
    logic [2:0]      ns_lamp;
    logic [2:0]      we_lamp;
    logic            fault;
    logic [1:0]      fault_code;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model state: colours as 0=red, 1=yellow, 2=green, 3=out of range.
    int         m_fault, m_code, m_prev_ns, m_prev_we, m_run, m_phase, m_bcnt;
    logic [2:0] exp_ns_lamp, exp_we_lamp;

    always #5 clock = ~clock;

    tlight_lamp_guard #(
        .BLINK_HALF_PERIOD(HP),
        .WATCHDOG_LIMIT(WL)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ns(ns),
        .we(we),
        .clear_fault(clear_fault),
        .ns_lamp(ns_lamp),
        .we_lamp(we_lamp),
        .fault(fault),
        .fault_code(fault_code)
    );

    function automatic logic [2:0] lamp_of(int c);
        case (c)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic void model_reset();
        m_fault = 0; m_code = 0; m_prev_ns = 0; m_prev_we = 0;
        m_run = 1; m_phase = 1; m_bcnt = 0;
        exp_ns_lamp = 3'b100; exp_we_lamp = 3'b100;
    endfunction

    function automatic void model_step(int n, int w, bit clr);
        int code;
        if (m_fault == 0) begin
            code = 0;
            if (n != 0 && w != 0) code = 1;
            else if (n > 2 || w > 2) code = 2;
            else if ((n - m_prev_ns) * (n - m_prev_ns) == 4 ||
                     (w - m_prev_we) * (w - m_prev_we) == 4) code = 2;
            else begin
                m_run = (n == m_prev_ns && w == m_prev_we) ? m_run + 1 : 1;
                if (m_run > WL) code = 3;
            end
            if (code != 0) begin
                m_fault = 1; m_code = code; m_phase = 1; m_bcnt = 0;
                exp_ns_lamp = 3'b010; exp_we_lamp = 3'b010;
            end else begin
                m_prev_ns = n; m_prev_we = w;
                exp_ns_lamp = lamp_of(n); exp_we_lamp = lamp_of(w);
            end
        end else if (clr && n == 0 && w == 0) begin
            model_reset();
        end else begin
            m_bcnt = m_bcnt + 1;
            if (m_bcnt == HP) begin
                m_bcnt = 0;
                m_phase = 1 - m_phase;
            end
            exp_ns_lamp = (m_phase != 0) ? 3'b010 : 3'b000;
            exp_we_lamp = exp_ns_lamp;
        end
    endfunction

    task automatic check_output(string name, logic [2:0] act, logic [2:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    task automatic apply_stimulus(int n, int w, bit clr);
        logic [1:0] nb, wb;
        nb = n[1:0];
        wb = w[1:0];
        ns = tlight_control_t'(nb);
        we = tlight_control_t'(wb);
        clear_fault = clr;
        @(posedge clock);
        model_step(n, w, clr);
        #1;
    endtask

    // Outputs settle after the rising edge; compare on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check_output("ns_lamp", ns_lamp, exp_ns_lamp);
            check_output("we_lamp", we_lamp, exp_we_lamp);
            check_output("fault", {2'b00, fault}, (m_fault != 0) ? 3'b001 : 3'b000);
            check_output("fault_code", {1'b0, fault_code}, 3'(m_code));
        end
    end

    function automatic int step_color(int c);
        if (c == 1) return ($urandom_range(0, 1) == 0) ? 0 : 2;
        if (c == 0 || c == 2) return 1;
        return 0;
    endfunction

    int seq_ns[7]  = '{0, 0, 0, 0, 1, 2, 1};
    int seq_we[7]  = '{0, 1, 2, 1, 0, 0, 0};
    int seq_len[7] = '{1, 3, 15, 1, 3, 15, 1};

    initial begin
        int cn, cw, r;
        bit clr;
        model_reset();
        #12;
        check_output("reset ns_lamp", ns_lamp, 3'b100);
        check_output("reset we_lamp", we_lamp, 3'b100);
        check_output("reset fault", {2'b00, fault}, 3'b000);
        check_output("reset code", {1'b0, fault_code}, 3'b000);
        chk_en = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Nominal controller cycle, three rounds.
        for (int round = 0; round < 3; round++)
            for (int s = 0; s < 7; s++)
                for (int k = 0; k < seq_len[s]; k++)
                    apply_stimulus(seq_ns[s], seq_we[s], 1'b0);
        check_output("nominal fault", {2'b00, fault}, 3'b000);
        check_output("nominal ns_lamp", ns_lamp, 3'b010);
        check_output("nominal we_lamp", we_lamp, 3'b100);

        // Conflict, blink, ignored clear, honoured clear.
        apply_stimulus(2, 1, 1'b0);
        check_output("conflict fault", {2'b00, fault}, 3'b001);
        check_output("conflict code", {1'b0, fault_code}, 3'b001);
        check_output("conflict ns_lamp", ns_lamp, 3'b010);
        check_output("conflict we_lamp", we_lamp, 3'b010);
        apply_stimulus(2, 1, 1'b0);
        check_output("blink off", ns_lamp, 3'b000);
        apply_stimulus(1, 0, 1'b1);
        check_output("ignored clear fault", {2'b00, fault}, 3'b001);
        check_output("ignored clear code", {1'b0, fault_code}, 3'b001);
        check_output("blink on", we_lamp, 3'b010);
        apply_stimulus(0, 0, 1'b1);
        check_output("clear fault", {2'b00, fault}, 3'b000);
        check_output("clear code", {1'b0, fault_code}, 3'b000);
        check_output("clear ns_lamp", ns_lamp, 3'b100);

        // Illegal red->green jump, then out-of-range encoding.
        apply_stimulus(2, 0, 1'b0);
        check_output("jump code", {1'b0, fault_code}, 3'b010);
        apply_stimulus(0, 0, 1'b1);
        apply_stimulus(0, 3, 1'b0);
        check_output("encoding code", {1'b0, fault_code}, 3'b010);
        apply_stimulus(0, 0, 1'b1);

        // Watchdog: WL samples legal, the next one faults.
        apply_stimulus(0, 1, 1'b0);
        for (int k = 0; k < WL; k++) apply_stimulus(0, 2, 1'b0);
        check_output("watchdog limit fault", {2'b00, fault}, 3'b000);
        check_output("watchdog limit we_lamp", we_lamp, 3'b001);
        apply_stimulus(0, 2, 1'b0);
        check_output("watchdog fault", {2'b00, fault}, 3'b001);
        check_output("watchdog code", {1'b0, fault_code}, 3'b011);
        apply_stimulus(0, 0, 1'b1);

        // Asynchronous reset in the middle of a fault.
        apply_stimulus(0, 1, 1'b0);
        apply_stimulus(2, 1, 1'b0);
        apply_stimulus(0, 0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_output("async ns_lamp", ns_lamp, 3'b100);
        check_output("async we_lamp", we_lamp, 3'b100);
        check_output("async fault", {2'b00, fault}, 3'b000);
        check_output("async code", {1'b0, fault_code}, 3'b000);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int s = 0; s < 7; s++)
            for (int k = 0; k < seq_len[s]; k++)
                apply_stimulus(seq_ns[s], seq_we[s], 1'b0);
        check_output("post reset fault", {2'b00, fault}, 3'b000);

        // Random walk over colours with occasional garbage and clear requests.
        cn = 1; cw = 0;
        repeat (800) begin
            r = int'($urandom_range(0, 99));
            if (m_fault != 0 && r < 40) begin
                cn = 0; cw = 0;
            end else if (r < 55) begin
                cn = cn;
            end else if (r < 75) begin
                cn = step_color(cn);
            end else if (r < 95) begin
                cw = step_color(cw);
            end else begin
                cn = int'($urandom_range(0, 3));
                cw = int'($urandom_range(0, 3));
            end
            clr = ($urandom_range(0, 3) == 0);
            apply_stimulus(cn, cw, clr);
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
